// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared opcode, state and datapath-select encodings for the RV32 subset core
package rv_ctrl_pkg;

    // Major opcodes of the supported RV32 subset (IR[6:0])
    localparam logic [6:0] OPC_RT  = 7'b0110011;
    localparam logic [6:0] OPC_IT  = 7'b0010011;
    localparam logic [6:0] OPC_LW  = 7'b0000011;
    localparam logic [6:0] OPC_SW  = 7'b0100011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;

    // Sequencer states
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_TRAP     = 4'd10
    } state_e;

    // ALU operand A select
    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRC_B_RS2   = 2'b00;
    localparam logic [1:0] SRC_B_FOUR  = 2'b01;
    localparam logic [1:0] SRC_B_IMM   = 2'b10;

    // ALU operation class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // States that own the memory port and therefore run the timeout counter
    function automatic logic is_mem_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle FSM sequencer for the shared ALU / unified memory datapath
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int RETIRE_W    = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                iord,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                pcsrc,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          aluop,
    output logic                memtoreg,
    output logic                regwrite,
    output logic                illegal,
    output logic                bus_err,
    output logic [RETIRE_W-1:0] retired
);

    // Counter holds 0..MEM_TIMEOUT-1 wait cycles already spent in the current memory state
    localparam int             TO_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [TO_W-1:0]       cnt_q, cnt_d;
    logic [RETIRE_W-1:0]   retired_q;
    logic                  illegal_q, bus_err_q;

    logic                  retire, set_illegal, set_bus_err, timeout_hit;
    logic                  mem_req_c, mem_we_c, iord_c, ir_write_c, pc_write_c;
    logic                  pc_write_cond_c, pcsrc_c, memtoreg_c, regwrite_c;
    logic [1:0]            alu_src_a_c, alu_src_b_c, aluop_c;

    // The zero flag gates pc_write_cond inside the datapath; the sequencer only carries it
    logic                  unused_zero;
    assign unused_zero = zero;

    // This cycle would be the MEM_TIMEOUT-th wait cycle if ready does not arrive now
    assign timeout_hit = (cnt_q == TO_LIMIT);

    // Next-state, strobe decode and timeout counter update
    always_comb begin
        state_d         = state_q;
        cnt_d           = '0;
        retire          = 1'b0;
        set_illegal     = 1'b0;
        set_bus_err     = 1'b0;
        mem_req_c       = 1'b0;
        mem_we_c        = 1'b0;
        iord_c          = 1'b0;
        ir_write_c      = 1'b0;
        pc_write_c      = 1'b0;
        pc_write_cond_c = 1'b0;
        pcsrc_c         = 1'b0;
        memtoreg_c      = 1'b0;
        regwrite_c      = 1'b0;
        alu_src_a_c     = SRC_A_PC;
        alu_src_b_c     = SRC_B_RS2;
        aluop_c         = ALUOP_ADD;

        case (state_q)
            S_FETCH: begin
                mem_req_c   = 1'b1;
                alu_src_b_c = SRC_B_FOUR;
                // PC+4 and IR load happen exactly on the completing cycle
                ir_write_c  = mem_ready;
                pc_write_c  = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d     = S_TRAP;
                    set_bus_err = 1'b1;
                end
            end
            S_DECODE: begin
                // Speculative branch target PC_old + imm parked in ALUOut
                alu_src_a_c = SRC_A_OLDPC;
                alu_src_b_c = SRC_B_IMM;
                case (opcode)
                    OPC_RT:         state_d = S_EXEC_R;
                    OPC_IT:         state_d = S_EXEC_I;
                    OPC_LW, OPC_SW: state_d = S_MEM_ADDR;
                    OPC_BEQ:        state_d = S_BRANCH;
                    default: begin
                        state_d     = S_TRAP;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a_c = SRC_A_RS1;
                alu_src_b_c = SRC_B_RS2;
                aluop_c     = ALUOP_FUNCT;
                state_d     = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a_c = SRC_A_RS1;
                alu_src_b_c = SRC_B_IMM;
                state_d     = S_ALU_WB;
            end
            S_ALU_WB: begin
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
                retire     = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_src_a_c = SRC_A_RS1;
                alu_src_b_c = SRC_B_IMM;
                // Only LW and SW reach here, and IR is stable, so one opcode compare suffices
                state_d     = (opcode == OPC_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_req_c = 1'b1;
                iord_c    = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (timeout_hit) begin
                    state_d     = S_TRAP;
                    set_bus_err = 1'b1;
                end
            end
            S_MEM_WB: begin
                regwrite_c = 1'b1;
                memtoreg_c = 1'b1;
                state_d    = S_FETCH;
                retire     = 1'b1;
            end
            S_MEM_WR: begin
                mem_req_c = 1'b1;
                mem_we_c  = 1'b1;
                iord_c    = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if (timeout_hit) begin
                    state_d     = S_TRAP;
                    set_bus_err = 1'b1;
                end
            end
            S_BRANCH: begin
                alu_src_a_c     = SRC_A_RS1;
                alu_src_b_c     = SRC_B_RS2;
                aluop_c         = ALUOP_SUB;
                pc_write_cond_c = 1'b1;
                pcsrc_c         = 1'b1;
                state_d         = S_FETCH;
                retire          = 1'b1;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase

        // Counting restarts whenever a memory state is (re)entered
        if ((state_d == state_q) && is_mem_state(state_q)) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    // State, timeout counter and sticky trap flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_q | set_illegal;
            bus_err_q <= bus_err_q | set_bus_err;
        end
    end

    // Retired-instruction counter, wraps at 2^RETIRE_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + RETIRE_W'(1);
        end
    end

    // Reset forces every strobe low immediately, so an aborted writeback never fires
    assign mem_req       = mem_req_c       & ~rst;
    assign mem_we        = mem_we_c        & ~rst;
    assign iord          = iord_c          & ~rst;
    assign ir_write      = ir_write_c      & ~rst;
    assign pc_write      = pc_write_c      & ~rst;
    assign pc_write_cond = pc_write_cond_c & ~rst;
    assign pcsrc         = pcsrc_c         & ~rst;
    assign memtoreg      = memtoreg_c      & ~rst;
    assign regwrite      = regwrite_c      & ~rst;
    assign alu_src_a     = rst ? 2'b00 : alu_src_a_c;
    assign alu_src_b     = rst ? 2'b00 : alu_src_b_c;
    assign aluop         = rst ? 2'b00 : aluop_c;
    assign illegal       = illegal_q;
    assign bus_err       = bus_err_q;
    assign retired       = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    localparam int RW = 2;
    localparam int TO = 4;

    // Expected control word: {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
    //                         pcsrc, alu_src_a, alu_src_b, aluop, memtoreg, regwrite}
    localparam logic [14:0] FW    = 15'b1_0_0_0_0_0_0_00_01_00_0_0;
    localparam logic [14:0] FD    = 15'b1_0_0_1_1_0_0_00_01_00_0_0;
    localparam logic [14:0] DEC   = 15'b0_0_0_0_0_0_0_01_10_00_0_0;
    localparam logic [14:0] EXR   = 15'b0_0_0_0_0_0_0_10_00_10_0_0;
    localparam logic [14:0] EXI   = 15'b0_0_0_0_0_0_0_10_10_00_0_0;
    localparam logic [14:0] ALUWB = 15'b0_0_0_0_0_0_0_00_00_00_0_1;
    localparam logic [14:0] MADDR = 15'b0_0_0_0_0_0_0_10_10_00_0_0;
    localparam logic [14:0] MRD   = 15'b1_0_1_0_0_0_0_00_00_00_0_0;
    localparam logic [14:0] MWB   = 15'b0_0_0_0_0_0_0_00_00_00_1_1;
    localparam logic [14:0] MWR   = 15'b1_1_1_0_0_0_0_00_00_00_0_0;
    localparam logic [14:0] BR    = 15'b0_0_0_0_0_1_1_10_00_01_0_0;
    localparam logic [14:0] NONE  = 15'b0;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    opcode;
    logic          zero, mem_ready;
    logic          mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pcsrc;
    logic [1:0]    alu_src_a, alu_src_b, aluop;
    logic          memtoreg, regwrite, illegal, bus_err;
    logic [RW-1:0] retired;

    always #5 clk = ~clk;

    multicycle_ctrl #(.RETIRE_W(RW), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pcsrc(pcsrc),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop),
        .memtoreg(memtoreg), .regwrite(regwrite), .illegal(illegal),
        .bus_err(bus_err), .retired(retired)
    );

    wire [14:0] ctl = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pcsrc,
                       alu_src_a, alu_src_b, aluop, memtoreg, regwrite};

    typedef struct {
        logic [6:0]  op;
        logic        zero;
        logic        rdy;
        logic [14:0] exp;
        logic        ill;
        logic        berr;
        int          ret;
    } cyc_t;

    cyc_t script[$];
    cyc_t tbl[10];
    int   ret_m;
    int   checks;
    int   failures;
    int   cyc_no;

    function automatic logic [6:0] rnd_op();
        return 7'($urandom);
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] kind_op(input int k);
        case (k)
            0: return OP_R;
            1: return OP_I;
            2: return OP_LW;
            3: return OP_SW;
            default: return OP_BEQ;
        endcase
    endfunction

    task automatic check_cycle(input cyc_t c, input string name);
        logic [RW-1:0] er;
        er = c.ret[RW-1:0];
        checks++;
        if (ctl !== c.exp || retired !== er || illegal !== c.ill || bus_err !== c.berr) begin
            failures++;
            $display("FAIL %s cycle%0d: ctl=%b ill=%b berr=%b retired=%0d, expected ctl=%b ill=%b berr=%b retired=%0d",
                     name, cyc_no, ctl, illegal, bus_err, retired, c.exp, c.ill, c.berr, er);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (ctl !== NONE || illegal !== 1'b0 || bus_err !== 1'b0 || retired !== '0) begin
            failures++;
            $display("FAIL %s: ctl=%b ill=%b berr=%b retired=%0d, expected all zero",
                     name, ctl, illegal, bus_err, retired);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, check at the falling edge
    task automatic apply(input cyc_t c, input string name);
        opcode    = c.op;
        zero      = c.zero;
        mem_ready = c.rdy;
        @(negedge clk);
        check_cycle(c, name);
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    task automatic run_script(input string name);
        cyc_t c;
        while (script.size() > 0) begin
            c = script.pop_front();
            apply(c, name);
        end
    endtask

    task automatic push(input logic [6:0] op, input logic rdy, input logic [14:0] exp,
                        input logic ill, input logic berr);
        cyc_t c;
        c.op   = op;
        c.zero = rb();
        c.rdy  = rdy;
        c.exp  = exp;
        c.ill  = ill;
        c.berr = berr;
        c.ret  = ret_m;
        script.push_back(c);
    endtask

    task automatic add_fetch(input int fw);
        for (int i = 0; i < fw; i++) push(rnd_op(), 1'b0, FW, 1'b0, 1'b0);
        push(rnd_op(), 1'b1, FD, 1'b0, 1'b0);
    endtask

    // One instruction expanded into its cycle script; fw/mw = wait cycles before ready
    task automatic add_instr(input int k, input int fw, input int mw);
        logic [6:0] op;
        op = kind_op(k);
        add_fetch(fw);
        push(op, rb(), DEC, 1'b0, 1'b0);
        case (k)
            0: begin push(op, rb(), EXR, 1'b0, 1'b0); push(op, rb(), ALUWB, 1'b0, 1'b0); end
            1: begin push(op, rb(), EXI, 1'b0, 1'b0); push(op, rb(), ALUWB, 1'b0, 1'b0); end
            2: begin
                push(op, rb(), MADDR, 1'b0, 1'b0);
                for (int i = 0; i < mw; i++) push(op, 1'b0, MRD, 1'b0, 1'b0);
                push(op, 1'b1, MRD, 1'b0, 1'b0);
                push(op, rb(), MWB, 1'b0, 1'b0);
            end
            3: begin
                push(op, rb(), MADDR, 1'b0, 1'b0);
                for (int i = 0; i < mw; i++) push(op, 1'b0, MWR, 1'b0, 1'b0);
                push(op, 1'b1, MWR, 1'b0, 1'b0);
            end
            default: push(op, rb(), BR, 1'b0, 1'b0);
        endcase
        ret_m++;
    endtask

    task automatic reset_pulse(input string name);
        rst = 1'b1;
        #1;
        check_all_zero(name);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        ret_m = 0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc_no   = 0;
        ret_m    = 0;

        // ADDI with ready tied high, then BEQ taken and not taken
        tbl[0] = '{OP_I,   1'b0, 1'b1, FD,    1'b0, 1'b0, 0};
        tbl[1] = '{OP_I,   1'b0, 1'b1, DEC,   1'b0, 1'b0, 0};
        tbl[2] = '{OP_I,   1'b0, 1'b1, EXI,   1'b0, 1'b0, 0};
        tbl[3] = '{OP_I,   1'b0, 1'b1, ALUWB, 1'b0, 1'b0, 0};
        tbl[4] = '{OP_BEQ, 1'b1, 1'b1, FD,    1'b0, 1'b0, 1};
        tbl[5] = '{OP_BEQ, 1'b1, 1'b1, DEC,   1'b0, 1'b0, 1};
        tbl[6] = '{OP_BEQ, 1'b1, 1'b1, BR,    1'b0, 1'b0, 1};
        tbl[7] = '{OP_BEQ, 1'b0, 1'b1, FD,    1'b0, 1'b0, 2};
        tbl[8] = '{OP_BEQ, 1'b0, 1'b1, DEC,   1'b0, 1'b0, 2};
        tbl[9] = '{OP_BEQ, 1'b0, 1'b1, BR,    1'b0, 1'b0, 2};

        // Reset held: every output must be zero even with ready asserted
        rst       = 1'b1;
        opcode    = OP_LW;
        zero      = 1'b1;
        mem_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_all_zero("reset_hold");
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) apply(tbl[i], "table");
        ret_m = 3;

        // LW with ready delayed 3 cycles in MEM_RD, followed by ADDI to observe retire
        add_instr(2, 0, 3);
        add_instr(1, 0, 0);
        run_script("lw_delay");

        // Unsupported opcodes trap, stay trapped, and only reset clears them
        add_fetch(1);
        push(7'b1111111, rb(), DEC, 1'b0, 1'b0);
        repeat (5) push(rnd_op(), rb(), NONE, 1'b1, 1'b0);
        run_script("illegal_7f");
        reset_pulse("illegal_reset");
        add_fetch(0);
        push(7'b1101111, rb(), DEC, 1'b0, 1'b0);
        repeat (3) push(rnd_op(), rb(), NONE, 1'b1, 1'b0);
        run_script("illegal_jal");
        reset_pulse("illegal_reset2");

        // SW never acknowledged: bus error after four wait cycles
        add_fetch(0);
        push(OP_SW, rb(), DEC, 1'b0, 1'b0);
        push(OP_SW, rb(), MADDR, 1'b0, 1'b0);
        repeat (TO) push(OP_SW, 1'b0, MWR, 1'b0, 1'b0);
        repeat (4) push(rnd_op(), rb(), NONE, 1'b0, 1'b1);
        run_script("timeout");
        reset_pulse("timeout_reset");

        // Ready on the last permitted cycle in every memory state completes normally
        add_instr(3, TO - 1, TO - 1);
        add_instr(2, TO - 1, TO - 1);
        add_instr(0, 0, 0);
        run_script("limit_ready");

        // Randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            add_instr($urandom_range(0, 4), $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));
        end
        run_script("random");

        // Reset in MEM_WB: writeback strobe drops without waiting for a clock
        add_instr(2, 0, 1);
        void'(script.pop_back());
        ret_m--;
        run_script("pre_abort");
        opcode    = OP_LW;
        mem_ready = 1'b0;
        #1;
        checks++;
        if (regwrite !== 1'b1 || memtoreg !== 1'b1) begin
            failures++;
            $display("FAIL mem_wb_entry: regwrite=%b memtoreg=%b, expected 1 1", regwrite, memtoreg);
        end
        reset_pulse("abort_mem_wb");

        // Five instructions after the abort; 2-bit counter reads 5 mod 4
        for (int n = 0; n < 5; n++) add_instr($urandom_range(0, 4), $urandom_range(0, 2), $urandom_range(0, 2));
        add_fetch(0);
        run_script("post_abort");
        checks++;
        if (retired !== 2'd1) begin
            failures++;
            $display("FAIL retired_wrap: retired=%0d, expected 1", retired);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
